// File: rtl/kar_pkg.sv
// Shared definitions for the kar truth-table sweeper.
// Vector count, index width, FSM states and the index-to-pin mapping.
package kar_pkg;

    localparam int KAR_NVEC  = 16;
    localparam int KAR_IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // {a,b,c,d} with a as the MSB of the vector index
    function automatic logic [3:0] vec2abcd(input logic [KAR_IDX_W-1:0] idx);
        return idx;
    endfunction

endpackage

// File: rtl/kar_sweep.sv
// Drives all 16 input vectors into kar, samples out after a settle delay,
// and compares the observed truth table against an expected minterm mask.
module kar_sweep
    import kar_pkg::*;
#(
    parameter logic [15:0] EXPECT = 16'h0000,
    parameter int          SETTLE = 1,
    parameter int          CNT_W  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        out,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] truth_table,
    output logic [4:0]  fail_cnt,
    output logic [3:0]  first_fail
);

    localparam logic [CNT_W-1:0]     SETTLE_C = CNT_W'(SETTLE);
    localparam logic [KAR_IDX_W-1:0] LAST_IDX = KAR_IDX_W'(KAR_NVEC - 1);

    state_t                 state_q, state_d;
    logic [KAR_IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [KAR_NVEC-1:0]    tt_q, tt_d;
    logic [4:0]             fc_q, fc_d;
    logic [KAR_IDX_W-1:0]   ff_q, ff_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        tt_d    = tt_q;
        fc_d    = fc_q;
        ff_d    = ff_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    idx_d   = '0;
                    cnt_d   = SETTLE_C;
                    tt_d    = '0;
                    fc_d    = '0;
                    ff_d    = '0;
                end
            end
            RUN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    tt_d[idx_q] = out;
                    if (out != EXPECT[idx_q]) begin
                        fc_d = fc_q + 5'd1;
                        if (fc_q == 5'd0) begin
                            ff_d = idx_q;
                        end
                    end
                    // last vector stays on the pins through DONE
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        cnt_d = SETTLE_C;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            tt_q    <= '0;
            fc_q    <= '0;
            ff_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tt_q    <= tt_d;
            fc_q    <= fc_d;
            ff_q    <= ff_d;
        end
    end

    assign {a, b, c, d}  = vec2abcd(idx_q);
    assign busy          = (state_q == RUN);
    assign done          = (state_q == DONE);
    assign pass          = done && (fc_q == 5'd0);
    assign truth_table   = tt_q;
    assign fail_cnt      = fc_q;
    assign first_fail    = ff_q;

endmodule
